// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the round-robin single-writer register arbiter:
// FSM state encoding and default geometry.
package reg_write_arbiter_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_W  = 8;
    localparam int DEF_IW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_LOAD  = 2'b10
    } state_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests and data in,
// grant/acknowledge/status and the shared register contents out.
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int IW = DEF_IW
);

    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [IW-1:0]  owner;
    logic           busy;
    logic [W-1:0]   q;

    modport master (
        output req, din,
        input  gnt, ack, owner, busy, q
    );

    modport slave (
        input  req, din,
        output gnt, ack, owner, busy, q
    );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotating-priority picker: index of the first set request bit searching
// ptr, ptr+1, ... N-1, 0, ... ptr-1.
module reg_write_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the unassigned path infers a latch.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = '0;
        // Walk from the farthest slot back to ptr so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter owning the single write port of a shared W-bit register:
// IDLE -> GRANT (owner chosen) -> LOAD (Q committed, Ack pulsed) -> GRANT/IDLE.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int IW = DEF_IW
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_write_arbiter_if.slave bus
);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] owner_inc;
    logic [N-1:0]  gnt_q;
    logic [W-1:0]  q_q;
    logic [N-1:0]  pick_req;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [W-1:0]  din_a [N];

    for (genvar i = 0; i < N; i++) begin : g_din
        assign din_a[i] = bus.din[i*W +: W];
    end

    assign owner_inc = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

    // In LOAD the search starts from the pointer value being written this edge,
    // and the current owner is masked out since its Req may still be high.
    assign pick_ptr    = (state_q == ST_LOAD) ? owner_inc : ptr_q;
    assign pick_req    = bus.req & ~gnt_q;
    assign pick_onehot = N'(1) << pick_idx;

    reg_write_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = pick_any ? ST_GRANT : ST_IDLE;
            ST_GRANT: state_d = ST_LOAD;
            ST_LOAD:  state_d = pick_any ? ST_GRANT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ack  = (state_q == ST_LOAD) ? gnt_q : '0;
        bus.busy = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
        end else begin
            if (state_q == ST_LOAD)
                ptr_q <= owner_inc;
            if ((state_q == ST_IDLE || state_q == ST_LOAD) && pick_any) begin
                owner_q <= pick_idx;
                gnt_q   <= pick_onehot;
            end else if (state_q == ST_LOAD) begin
                gnt_q   <= '0;
            end
        end
    end

    // NOTE: the shared register is architecturally visible state that must read
    // 0 after reset, so unlike a plain datapath pipe it takes the async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  q_q <= '0;
        else if (state_q == ST_GRANT) q_q <= din_a[owner_q];
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.q     = q_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter: reset, single write,
// full rotation, pointer wrap, Req drop in GRANT and reset abort in LOAD.
module tb_reg_write_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    reg_write_arbiter_if #(.N(4), .W(8), .IW(2)) bus ();

    reg_write_arbiter #(.N(4), .W(8), .IW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_state(input string tag, input logic [3:0] gnt, input logic [3:0] ack,
                                input logic busy, input logic [1:0] owner, input logic [7:0] q);
        check({tag, ".gnt"},   32'(bus.gnt),   32'(gnt));
        check({tag, ".ack"},   32'(bus.ack),   32'(ack));
        check({tag, ".busy"},  32'(bus.busy),  32'(busy));
        check({tag, ".owner"}, 32'(bus.owner), 32'(owner));
        check({tag, ".q"},     32'(bus.q),     32'(q));
    endtask

    initial begin
        rst_n   = 1'b1;
        bus.req = '0;
        bus.din = '0;

        // 1: asynchronous reset takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1 expect_state("rst_async", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        expect_state("rst_release", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);

        // 2: single write from requester 1
        bus.din = 32'h44_33_A5_11;
        bus.req = 4'b0010;
        step();
        expect_state("single_grant", 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h00);
        step();
        expect_state("single_load", 4'b0010, 4'b0010, 1'b1, 2'd1, 8'hA5);
        bus.req = 4'b0000;
        step();
        expect_state("single_idle", 4'b0000, 4'b0000, 1'b0, 2'd1, 8'hA5);

        // 3: all four requesting from ptr=0, each dropped on its Ack
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        bus.din = 32'h44_33_22_11;
        bus.req = 4'b1111;
        step();
        expect_state("rr_g0", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h00);
        step();
        expect_state("rr_l0", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h11);
        bus.req = 4'b1110;
        step();
        expect_state("rr_g1", 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h11);
        step();
        expect_state("rr_l1", 4'b0010, 4'b0010, 1'b1, 2'd1, 8'h22);
        bus.req = 4'b1100;
        step();
        expect_state("rr_g2", 4'b0100, 4'b0000, 1'b1, 2'd2, 8'h22);
        step();
        expect_state("rr_l2", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h33);
        bus.req = 4'b1000;
        step();
        expect_state("rr_g3", 4'b1000, 4'b0000, 1'b1, 2'd3, 8'h33);
        step();
        expect_state("rr_l3", 4'b1000, 4'b1000, 1'b1, 2'd3, 8'h44);
        bus.req = 4'b0000;
        step();
        expect_state("rr_idle", 4'b0000, 4'b0000, 1'b0, 2'd3, 8'h44);

        // 4: grant 2 leaves ptr=3, then 1001 serves 3 before 0, then 0001 wraps to 0
        bus.din = 32'h44_77_22_11;
        bus.req = 4'b0100;
        step();
        step();
        expect_state("wrap_l2", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h77);
        bus.req = 4'b0000;
        step();
        bus.din = 32'hC3_77_22_0C;
        bus.req = 4'b1001;
        step();
        expect_state("wrap_g3", 4'b1000, 4'b0000, 1'b1, 2'd3, 8'h77);
        step();
        expect_state("wrap_l3", 4'b1000, 4'b1000, 1'b1, 2'd3, 8'hC3);
        bus.req = 4'b0001;
        step();
        expect_state("wrap_g0", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'hC3);
        step();
        expect_state("wrap_l0", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h0C);
        bus.req = 4'b0000;
        step();
        expect_state("wrap_idle", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h0C);
        bus.din = 32'hC3_77_22_D2;
        bus.req = 4'b0001;
        step();
        expect_state("wrap_again_g0", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h0C);
        step();
        expect_state("wrap_again_l0", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'hD2);
        bus.req = 4'b0000;
        step();

        // 5: Req dropped during GRANT still completes the write
        bus.din = 32'h00_5A_00_00;
        bus.req = 4'b0100;
        step();
        expect_state("drop_grant", 4'b0100, 4'b0000, 1'b1, 2'd2, 8'hD2);
        bus.req = 4'b0000;
        step();
        expect_state("drop_load", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h5A);
        step();
        expect_state("drop_idle", 4'b0000, 4'b0000, 1'b0, 2'd2, 8'h5A);

        // 6: reset in LOAD aborts the write and clears Q at once
        bus.din = 32'h00_00_00_FF;
        bus.req = 4'b0001;
        step();
        step();
        expect_state("abort_load", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'hFF);
        #1 rst_n = 1'b0;
        #1 expect_state("abort_async", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        expect_state("abort_after", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        step();
        expect_state("abort_quiet", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
